// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch front end: opcode constants, the
// fetch entry record and the fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

    function automatic logic opcode_known(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH,
            OP_ITYPE, OP_JAL, OP_LUI: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: imem req/gnt/rvalid side plus the decode-facing instruction
// stream. instr_illegal_o exists only when IFETCH_OPCHECK_EN is defined.
interface ifetch_unit_if;

    // imem: a request is accepted on a cycle with req && gnt; responses come back
    // in order, one rvalid per grant, at least one cycle later. Decode: an
    // instruction transfers on a cycle with instr_valid_o && instr_ready_i.
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
`ifdef IFETCH_OPCHECK_EN
    logic        instr_illegal_o;
`endif

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
`ifdef IFETCH_OPCHECK_EN
        output instr_illegal_o,
`endif
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
`ifdef IFETCH_OPCHECK_EN
        input  instr_illegal_o,
`endif
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
        output instr_ready_i
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush wins over push/pop.
// Used both as the instruction buffer and as the in-order PC tag queue.
module ifetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited imem
// requests, tagged response buffering and redirect flush. Optional opcode
// legality output is enabled with IFETCH_OPCHECK_EN.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master bus,
    output fetch_state_t  dbg_state
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam int OW  = 8;
    localparam logic [CW:0] DEPTH_C = CW1'(FIFO_DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [OW-1:0] outstanding_nxt;

    fetch_entry_t  head;
    fetch_entry_t  tag_head;
    fetch_entry_t  instr_din;
    fetch_entry_t  tag_din;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] tag_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          tag_full;
    logic          tag_empty;

    logic          credit_ok;
    logic          grant;
    logic          resp_keep;
    logic          resp_drop;
    logic          pop;

    // tag_count tracks live (non-discarded) in-flight requests, so buffered plus
    // live never exceeds the buffer depth and the buffer cannot overflow.
    assign credit_ok = (({1'b0, fifo_count} + {1'b0, tag_count}) < DEPTH_C)
                       && (outstanding != '1);

    assign bus.imem_req_o  = (state == FETCH_RUN) && credit_ok;
    assign bus.imem_addr_o = fetch_pc;

    assign grant     = bus.imem_req_o && bus.imem_gnt_i;
    assign resp_drop = bus.imem_rvalid_i && (discard != '0);
    assign resp_keep = bus.imem_rvalid_i && (discard == '0);
    assign pop       = !fifo_empty && bus.instr_ready_i;

    assign outstanding_nxt = outstanding + OW'(grant) - OW'(bus.imem_rvalid_i);

    assign tag_din   = '{pc: fetch_pc, instr: '0};
    assign instr_din = '{pc: tag_head.pc, instr: bus.imem_rdata_i};

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH_BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (state == FETCH_BOOT) state <= FETCH_RUN;
            outstanding <= outstanding_nxt;
            if (bus.redirect_i) begin
                // Everything still in flight after this cycle, including a grant
                // taken on this very cycle, belongs to the old path.
                fetch_pc <= bus.redirect_pc_i & 32'hFFFF_FFFC;
                discard  <= outstanding_nxt;
            end else begin
                if (grant)     fetch_pc <= fetch_pc + 32'd4;
                if (resp_drop) discard  <= discard - OW'(1);
            end
        end
    end

    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .push  (grant && !bus.redirect_i),
        .din   (tag_din),
        .pop   (resp_keep),
        .flush (bus.redirect_i),
        .dout  (tag_head),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk   (clk),
        .reset (reset),
        .push  (resp_keep),
        .din   (instr_din),
        .pop   (pop),
        .flush (bus.redirect_i),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.instr_valid_o = !fifo_empty;
    assign bus.instr_o       = head.instr;
    assign bus.instr_pc_o    = head.pc;

`ifdef IFETCH_OPCHECK_EN
    assign bus.instr_illegal_o = !((head.instr[1:0] == 2'b11) && opcode_known(head.instr[6:0]));
`endif

`ifndef SYNTHESIS
    a_rvalid_has_request: assert property (@(posedge clk) disable iff (reset)
        bus.imem_rvalid_i |-> (outstanding != '0));
    a_keep_has_room: assert property (@(posedge clk) disable iff (reset)
        resp_keep |-> (!tag_empty && !fifo_full && (tag_head.instr == '0)));
    a_tag_has_room: assert property (@(posedge clk) disable iff (reset)
        (grant && !bus.redirect_i) |-> !tag_full);
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: in-order memory responder, expected-queue
// scoreboard for grant addresses and decoded instructions, final summary.
module tb_ifetch_unit;
    import riscv_pkg::*;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    fetch_state_t dbg_state;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          grant_cnt = 0;
    bit          stall = 1'b0;
    bit          resp_hold = 1'b0;
    logic [64:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] pend_q[$];
    logic [64:0] e;
    logic [31:0] ra;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h300) return 32'h0000_0013;
        if (a == 32'h304) return 32'h0000_0001;
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic ill);
        exp_q.push_back({ill, pc, instr});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout pending_instr=%0d pending_addr=%0d required=0",
                     name, exp_q.size(), exp_addr_q.size());
            exp_q.delete();
            exp_addr_q.delete();
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        pend_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        bus.imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("rst_req",   bus.imem_req_o,    0);
        check("rst_addr",  bus.imem_addr_o,   32'h0);
        check("rst_valid", bus.instr_valid_o, 0);
        check("rst_instr", bus.instr_o,       32'h0);
        check("rst_pc",    bus.instr_pc_o,    32'h0);
        check("rst_state", dbg_state,         FETCH_BOOT);
        @(posedge clk); #2;
        grant_cnt = 0;
        reset = 1'b0;
    endtask

    // Returns just after the redirect edge.
    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #2;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = pc;
        @(posedge clk); #2;
        bus.redirect_i    = 1'b0;
    endtask

    // Memory responder: one in-order response per cycle, one cycle after grant.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            pend_q.delete();
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end else if (!resp_hold && pend_q.size() != 0) begin
            ra = pend_q.pop_front();
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(ra);
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.instr_ready_i = !stall && (exp_q.size() != 0);
    end

    // Grant monitor: records requests for the responder, checks addresses.
    always @(negedge clk) begin
        if (!reset && bus.imem_req_o && bus.imem_gnt_i) begin
            grant_cnt++;
            pend_q.push_back(bus.imem_addr_o);
            if (exp_addr_q.size() != 0) check("grant_addr", bus.imem_addr_o, exp_addr_q.pop_front());
        end
    end

    // Instruction monitor: every decode handshake is scored against exp_q.
    always @(negedge clk) begin
        if (!reset && bus.instr_valid_o && bus.instr_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr actual_pc=%h required=none", bus.instr_pc_o);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc",   bus.instr_pc_o, e[63:32]);
                check("instr_word", bus.instr_o,    e[31:0]);
`ifdef IFETCH_OPCHECK_EN
                check("instr_illegal", bus.instr_illegal_o, e[64]);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;

        // Boot and first fetches.
        apply_reset();
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        push_exp(32'h0, 32'h0000_0013, 1'b0);
        push_exp(32'h4, 32'h0000_0413, 1'b0);
        @(negedge clk);
        check("boot_state", dbg_state, FETCH_BOOT);
        check("boot_req",   bus.imem_req_o, 0);
        @(negedge clk);
        check("run_state",  dbg_state, FETCH_RUN);
        check("run_req",    bus.imem_req_o, 1);
        wait_drain("first_fetch");

        // Decode stall, then a held request while gnt is low.
        stall = 1'b1;
        apply_reset();
        repeat (11) @(negedge clk);
        check("stall_grants",  grant_cnt, 2);
        check("stall_req",     bus.imem_req_o, 0);
        check("stall_valid",   bus.instr_valid_o, 1);
        check("stall_head_pc", bus.instr_pc_o, 32'h0);
        check("stall_head",    bus.instr_o, 32'h0000_0013);
        bus.imem_gnt_i = 1'b0;
        push_exp(32'h0, 32'h0000_0013, 1'b0);
        push_exp(32'h4, 32'h0000_0413, 1'b0);
        push_exp(32'h8, 32'h0000_0813, 1'b0);
        push_exp(32'hC, 32'h0000_0C13, 1'b0);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        stall = 1'b0;
        for (int n = 0; n < 20 && !bus.imem_req_o; n++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("hold_req",  bus.imem_req_o, 1);
            check("hold_addr", bus.imem_addr_o, 32'h8);
            @(negedge clk);
        end
        bus.imem_gnt_i = 1'b1;
        wait_drain("stall_resume");

        // Redirect with two live requests held in memory.
        resp_hold = 1'b1;
        do_redirect(32'h40);
        exp_addr_q.push_back(32'h40);
        exp_addr_q.push_back(32'h44);
        @(negedge clk);
        check("redir1_valid", bus.instr_valid_o, 0);
        check("redir1_addr",  bus.imem_addr_o, 32'h40);
        wait_drain("redir1_grants");
        @(negedge clk);
        check("redir1_credit", bus.imem_req_o, 0);
        do_redirect(32'h100);
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h104);
        push_exp(32'h100, 32'h0001_0013, 1'b0);
        push_exp(32'h104, 32'h0001_0413, 1'b0);
        @(negedge clk);
        check("redir2_valid", bus.instr_valid_o, 0);
        check("redir2_addr",  bus.imem_addr_o, 32'h100);
        resp_hold = 1'b0;
        wait_drain("redir2_stream");

        // Unaligned target and address wrap.
        do_redirect(32'h203);
        exp_addr_q.push_back(32'h200);
        push_exp(32'h200, 32'h0002_0013, 1'b0);
        @(negedge clk);
        check("align_addr", bus.imem_addr_o, 32'h200);
        wait_drain("align");
        do_redirect(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        push_exp(32'hFFFF_FFFC, 32'hFFFF_FC13, 1'b0);
        push_exp(32'h0,         32'h0000_0013, 1'b0);
        wait_drain("wrap");

        // Back-to-back redirects: the second target wins.
        @(posedge clk); #2;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h500;
        @(posedge clk); #2;
        bus.redirect_pc_i = 32'h600;
        @(posedge clk); #2;
        bus.redirect_i    = 1'b0;
        exp_addr_q.push_back(32'h600);
        push_exp(32'h600, 32'h0006_0013, 1'b0);
        @(negedge clk);
        check("b2b_valid", bus.instr_valid_o, 0);
        check("b2b_addr",  bus.imem_addr_o, 32'h600);
        wait_drain("b2b");

        // Legal then illegal encoding.
        do_redirect(32'h300);
        exp_addr_q.push_back(32'h300);
        push_exp(32'h300, 32'h0000_0013, 1'b0);
        push_exp(32'h304, 32'h0000_0001, 1'b1);
        wait_drain("opcheck");

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end. Generates sequential PCs, issues requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small FIFO.
- Presents {instr, pc} to the decode stage with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing buffered and in-flight fetches.
- Acts as the producer end of the instruction interface that the main decoder consumes.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2); also caps the number of outstanding requests.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  32  fetch address, word aligned ([1:0]=0).
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata_i  input  32  response instruction word.
- redirect_i  input  1  take redirect this cycle.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored and forced to 0.
- instr_valid_o  output  1  instr_o/instr_pc_o valid.
- instr_o  output  32  instruction word.
- instr_pc_o  output  32  PC of instr_o.
- instr_ready_i  input  1  decode accepts the instruction (pop when valid && ready).

Behaviour:
- Reset (async, active-high):
  - FSM=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- FSM:
  - BOOT: one cycle after reset release with req=0, then RUN. Reset mid-operation returns to BOOT and drops everything.
- Credit rule:
  - imem_req_o=1 in RUN iff fifo_count + (outstanding - discard) < FIFO_DEPTH.
  - Pops in the same cycle are not credited, which is conservative.
  - The FIFO can never overflow.
- Request stability: once req=1 without gnt, req and addr stay stable until gnt. The only exception is a redirect, which may withdraw or retarget the request in the next cycle.
- Grant (req && gnt): fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); outstanding++.
- Response (rvalid):
  - outstanding-- in all cases.
  - If discard>0: discard-- and drop the data.
  - Otherwise push {pc, rdata} into the FIFO. The pc is the tag captured at grant, held in a small in-order tag queue of depth FIFO_DEPTH.
- Output:
  - FIFO head drives instr_o/instr_pc_o, and instr_valid_o = !empty.
  - Zero-cycle bypass is not allowed. Fetch-to-decode latency is 1 cycle after rvalid (FIFO registered).
- Redirect (highest priority):
  - Effects in the same cycle: FIFO flushed; fetch_pc <= {redirect_pc_i[31:2],2'b00}; discard <= outstanding after this cycle's gnt/rvalid updates, with non-discarded in-flight responses included.
  - A gnt on that cycle counts as an old-path request and is discarded.
  - Next cycle: instr_valid_o=0, and a new request may issue at the target if credit allows.
  - A pop on the redirect cycle is permitted; the popped instruction is assumed already consumed.
- Back-to-back redirects: the later one wins; discard accumulates correctly.
- No memory error handling; rvalid with outstanding==0 is a protocol violation and is flagged by an assertion.

Optional Feature:
- Macro: IFETCH_OPCHECK_EN.
- Defined:
  - Extra output instr_illegal_o, 1 bit, qualified by instr_valid_o.
  - Asserted when the head instr[1:0] != 2'b11, or when opcode [6:0] is not one of 0000011, 0100011, 0110011, 1100011, 0010011, 1101111, 0110111.
  - Computed combinationally from the FIFO head; no extra latency.
- Undefined: the port is absent and there is no check logic.

Decomposition:
- Shared package riscv_pkg:
  - Opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_LUI.
  - XLEN=32.
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module ifetch_fifo: synchronous FIFO of fetch_entry_t, FIFO_DEPTH entries, with push/pop/flush, count, full and empty. It is reused for the tag queue.

Test Plan:
- Reset release with gnt tied 1 and rvalid 1 cycle after gnt -> BOOT for 1 cycle; addrs 0x0, 0x4, 0x8; instr_pc_o 0x0, 0x4 in order, with instr matching the memory model.
- instr_ready_i=0 for 10 cycles -> at most 2 requests granted, FIFO holds PCs 0x0/0x4, req=0, then resumes in order after ready=1.
- gnt delayed 3 cycles -> req/addr=0x8 held stable for all 3 cycles.
- Redirect to 0x100 with 2 outstanding -> both old responses dropped; first valid instr_pc_o=0x100; no stale PC appears.
- redirect_pc_i=0x203 -> fetch addr 0x200. fetch_pc=0xFFFF_FFFC -> next address 0x0.
- With IFETCH_OPCHECK_EN, return 0x0000_0013 then 0x0000_0001 -> instr_illegal_o=0, then 1.
